dma_ar_arbiter: RTL and testbench
=================================

DMA_AR_ARBITER -- requirements
Module: dma_ar_arbiter

Interface
REQ-001 Parameter NCH, default 8: number of read requesters (m2l channels).
REQ-002 Parameter b, default 8: burst length field width.
REQ-003 Parameter w, default 32: AXI data width; sets arsize.
REQ-004 Parameter MAX_OUTS, default 4: maximum outstanding read bursts, range 1..15.
REQ-005 aclk  input  1  single clock, all logic on its rising edge.
REQ-006 areset  input  1  synchronous, active-high reset.
REQ-007 ch_req  input  NCH  per-channel read-burst request, held until granted.
REQ-008 ch_addr  input  NCH*32  per-channel burst start address, channel i at bits [32i+31:32i].
REQ-009 ch_len  input  NCH*b  per-channel AXI length (beats-1), channel i at bits [b*i+b-1:b*i].
REQ-010 ch_gnt  output  NCH  one-cycle pulse on the AR handshake of the owning channel.
REQ-011 arvalid  output  1  AXI read address valid.
REQ-012 arready  input  1  AXI read address ready.
REQ-013 araddr  output  32  latched address of the granted channel.
REQ-014 arlen  output  b  latched length of the granted channel.
REQ-015 arsize  output  3  constant log2(w/8); 3'b010 for w=32.
REQ-016 arburst  output  2  constant 2'b01 (INCR).
REQ-017 arid  output  6  granted channel index, zero-extended.
REQ-018 rvalid, rready, rlast  input  1 each  AXI read data channel, monitored only.
REQ-019 outs_cnt  output  4  current outstanding burst count.
REQ-020 err_underflow  output  1  sticky flag for rlast beat with outs_cnt==0.

Function
REQ-021 Two-state FSM, IDLE and ADDR.
REQ-022 IDLE to ADDR when |ch_req and outs_cnt<MAX_OUTS; the winner's addr, len and index latch at that edge.
REQ-023 Latency: ch_req high in cycle N (with IDLE and credit available) gives arvalid=1 in cycle N+1.
REQ-024 Arbitration is round-robin: search starts at rr_ptr, wraps from NCH-1 to 0; rr_ptr resets to 0.
REQ-025 In ADDR: arvalid=1; araddr, arlen and arid stay stable until arready=1.
REQ-026 ADDR handshake (arvalid & arready) takes these actions at that edge:
- ch_gnt[winner]=1 for exactly one cycle;
- rr_ptr updates to (winner+1) mod NCH;
- outs_cnt increments;
- FSM returns to IDLE.
REQ-027 Minimum spacing between consecutive AR handshakes is 2 cycles; back-to-back arvalid is not required.
REQ-028 Deasserting ch_req while in ADDR does not abort the request; the burst completes and the grant still pulses.
REQ-029 outs_cnt decrements on rvalid & rready & rlast.
REQ-030 Simultaneous increment and decrement leave outs_cnt unchanged.
REQ-031 outs_cnt==MAX_OUTS (full): FSM stays in IDLE; arvalid=0.
REQ-032 Decrement while outs_cnt==0: count stays 0 (no wrap) and err_underflow sets.
REQ-033 outs_cnt never exceeds MAX_OUTS.

Reset
REQ-034 areset=1 at an edge forces, at that edge:
- FSM=IDLE, arvalid=0, ch_gnt=0;
- araddr=0, arlen=0, arid=0;
- outs_cnt=0, rr_ptr=0, err_underflow=0.
REQ-035 Reset during ADDR drops arvalid at the reset edge; the pending request is discarded with no grant pulse.
REQ-036 The first arbitration is possible in the first cycle with areset=0.

Configuration
REQ-037 Macro DMA_AR_CH0_PRIO_EN defined: channel 0 has strict priority over all others whenever ch_req[0]=1, and rr_ptr is not updated on channel-0 grants.
REQ-038 DMA_AR_CH0_PRIO_EN undefined: pure round-robin per REQ-024, with channel 0 treated like every other channel.

Verification
REQ-039 Single request:
- Stimulus: ch_req=8'h04, ch_addr[2]=32'h1000_0040, ch_len[2]=8'h0F, arready=1.
- Required response: arvalid in the next cycle with araddr=32'h1000_0040, arlen=8'h0F, arid=2; ch_gnt=8'h04 for one cycle; outs_cnt=1.
REQ-040 Round-robin:
- Stimulus: ch_req=8'hFF held, arready=1, rlast returned after each burst.
- Required response: arid sequence 0,1,2,...,7,0; with DMA_AR_CH0_PRIO_EN defined, arid=0 every grant.
REQ-041 Backpressure:
- Stimulus: arready=0 for 5 cycles, with ch_req changing during those cycles.
- Required response: arvalid, araddr, arlen and arid stable for all 5 cycles; a single grant when arready=1.
REQ-042 Full:
- Stimulus: MAX_OUTS=4, four grants, no rlast.
- Required response: outs_cnt=4, arvalid stays 0; one rlast beat, then arvalid=1 one cycle after the decrement edge.
REQ-043 Simultaneous events:
- Stimulus: AR handshake and rlast beat in the same cycle at outs_cnt=2.
- Required response: outs_cnt remains 2.
REQ-044 Underflow and reset:
- Stimulus: rlast beat at outs_cnt=0, then areset during ADDR.
- Required response: err_underflow=1 after the rlast beat; at the reset edge arvalid=0, err_underflow=0, no ch_gnt pulse.

Source files
------------

// File: rtl/dma_ar_arbiter_if.sv
// ---------------------------------------------------------------------------
// dma_ar_arbiter_if
// Bundles the signals of the DMA read-address arbiter: the per-channel
// request side, the AXI AR channel, the monitored AXI R channel, and status.
//
// Handshake rule (all channels): a transfer happens on a rising edge where
// valid and ready are both 1. Once valid is raised, valid and the payload
// (araddr/arlen/arid) hold steady until that edge. Ready may change freely.
// ch_req acts as a valid that is held until its ch_gnt pulse.
//
// Ports (slave = arbiter side, master = requester/AXI/bench side):
//   ch_req[NCH], ch_addr[NCH*32], ch_len[NCH*b]  -> arbiter
//   ch_gnt[NCH]                                   <- arbiter
//   arvalid, araddr, arlen, arsize, arburst, arid <- arbiter
//   arready                                       -> arbiter
//   rvalid, rready, rlast                         -> arbiter (monitored)
//   outs_cnt, err_underflow, state_dbg            <- arbiter (status/debug)
// ---------------------------------------------------------------------------
interface dma_ar_arbiter_if #(
   parameter int NCH = 8,
   parameter int b   = 8
);
   logic [NCH-1:0]    ch_req;
   logic [NCH*32-1:0] ch_addr;
   logic [NCH*b-1:0]  ch_len;
   logic [NCH-1:0]    ch_gnt;
   logic              arvalid;
   logic              arready;
   logic [31:0]       araddr;
   logic [b-1:0]      arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [5:0]        arid;
   logic              rvalid;
   logic              rready;
   logic              rlast;
   logic [3:0]        outs_cnt;
   logic              err_underflow;
   logic              state_dbg;   // 0 = IDLE, 1 = ADDR

   modport slave (
      input  ch_req, ch_addr, ch_len, arready, rvalid, rready, rlast,
      output ch_gnt, arvalid, araddr, arlen, arsize, arburst, arid,
             outs_cnt, err_underflow, state_dbg
   );

   modport master (
      output ch_req, ch_addr, ch_len, arready, rvalid, rready, rlast,
      input  ch_gnt, arvalid, araddr, arlen, arsize, arburst, arid,
             outs_cnt, err_underflow, state_dbg
   );
endinterface

// File: rtl/dma_ar_arbiter.sv
// ---------------------------------------------------------------------------
// dma_ar_arbiter
// Round-robin arbiter that turns NCH per-channel read-burst requests into
// AXI AR transactions, while limiting the number of outstanding bursts to
// MAX_OUTS (a burst retires on its rlast beat).
//
// Ports:
//   aclk    - single clock, rising edge
//   areset  - synchronous, active-high reset
//   bus     - dma_ar_arbiter_if.slave (request, AR, R-monitor, status)
//
// Optional feature: define DMA_AR_CH0_PRIO_EN to give channel 0 strict
// priority whenever it requests; its grants then leave rr_ptr untouched.
// ---------------------------------------------------------------------------
module dma_ar_arbiter #(
   parameter int NCH      = 8,
   parameter int b        = 8,
   parameter int w        = 32,
   parameter int MAX_OUTS = 4
) (
   input logic            aclk,
   input logic            areset,
   dma_ar_arbiter_if.slave bus
);

   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic {IDLE = 1'b0, ADDR = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [31:0]     araddr_q, araddr_d;
   logic [b-1:0]    arlen_q, arlen_d;
   logic [PW-1:0]   arid_q, arid_d;
   logic [NCH-1:0]  gnt_q, gnt_d;
   logic [3:0]      outs_cnt_q, outs_cnt_d;
   logic            err_q, err_d;

   logic            found;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   idx_p;
   logic [PW-1:0]   rr_next;
   logic            inc;
   logic            dec;

   // Round-robin search starting at rr_ptr and wrapping at NCH-1.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      idx_p   = '0;
      for (int k = 0; k < NCH; k++) begin
         idx_p = PW'((int'(rr_ptr_q) + k) % NCH);
         if (!found && bus.ch_req[idx_p]) begin
            found   = 1'b1;
            win_idx = idx_p;
         end
      end
`ifdef DMA_AR_CH0_PRIO_EN
      if (bus.ch_req[0]) begin
         found   = 1'b1;
         win_idx = '0;
      end
`endif
   end

   assign rr_next = (arid_q == PW'(NCH - 1)) ? '0 : arid_q + 1'b1;
   assign dec     = bus.rvalid & bus.rready & bus.rlast;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      arid_d     = arid_q;
      gnt_d      = '0;
      inc        = 1'b0;
      outs_cnt_d = outs_cnt_q;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            // A free credit is required before a new burst may be offered.
            if (found && (outs_cnt_q < 4'(MAX_OUTS))) begin
               state_d  = ADDR;
               araddr_d = bus.ch_addr[int'(win_idx)*32 +: 32];
               arlen_d  = bus.ch_len[int'(win_idx)*b +: b];
               arid_d   = win_idx;
            end
         end
         ADDR: begin
            // The latched request is committed: a dropped ch_req does not
            // abort it, only reset does.
            if (bus.arready) begin
               inc     = 1'b1;
               gnt_d   = NCH'(1) << arid_q;
               state_d = IDLE;
`ifdef DMA_AR_CH0_PRIO_EN
               if (arid_q != '0) rr_ptr_d = rr_next;
`else
               rr_ptr_d = rr_next;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // A retiring burst and a new grant on the same edge cancel out.
      if (inc && !dec) begin
         outs_cnt_d = outs_cnt_q + 4'd1;
      end else if (dec && !inc) begin
         if (outs_cnt_q == 4'd0) err_d = 1'b1;
         else                    outs_cnt_d = outs_cnt_q - 4'd1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arid_q     <= '0;
         gnt_q      <= '0;
         outs_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arid_q     <= arid_d;
         gnt_q      <= gnt_d;
         outs_cnt_q <= outs_cnt_d;
         err_q      <= err_d;
      end
   end

   assign bus.arvalid       = (state_q == ADDR);
   assign bus.araddr        = araddr_q;
   assign bus.arlen         = arlen_q;
   assign bus.arid          = 6'(arid_q);
   assign bus.arsize        = 3'($clog2(w / 8));
   assign bus.arburst       = 2'b01;
   assign bus.ch_gnt        = gnt_q;
   assign bus.outs_cnt      = outs_cnt_q;
   assign bus.err_underflow = err_q;
   assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_dma_ar_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_ar_arbiter
// Directed bench for dma_ar_arbiter (NCH=8, b=8, w=32, MAX_OUTS=4).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_dma_ar_arbiter;

   localparam int NCH = 8;
   localparam int B   = 8;

   logic aclk = 1'b0;
   logic areset;

   int pass_cnt = 0;
   int total_cnt = 0;

   dma_ar_arbiter_if #(.NCH(NCH), .b(B)) bus ();

   dma_ar_arbiter #(.NCH(NCH), .b(B), .w(32), .MAX_OUTS(4)) dut (
      .aclk  (aclk),
      .areset(areset),
      .bus   (bus.slave)
   );

   // ---------------- clock ----------------
   always #5 aclk = ~aclk;

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Expected arid when channel 0 is also requesting.
   function automatic logic [5:0] exp_id(input int n);
`ifdef DMA_AR_CH0_PRIO_EN
      return 6'd0;
`else
      return 6'(n);
`endif
   endfunction

   task automatic rlast_beat();
      bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
      tick();
      bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      tick();
      areset = 1'b0;
   endtask

   logic [7:0] bp_req [5];

   initial begin
      areset      = 1'b1;
      bus.ch_req  = '0;
      bus.ch_addr = '0;
      bus.ch_len  = '0;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rready  = 1'b0;
      bus.rlast   = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         bus.ch_addr[32*i +: 32] = 32'h1000_0000 + 32'(i) * 32'h100;
         bus.ch_len[B*i +: B]    = 8'(i + 1);
      end
      bp_req[0] = 8'h01; bp_req[1] = 8'h80; bp_req[2] = 8'h00;
      bp_req[3] = 8'hFF; bp_req[4] = 8'h22;

      // ---------- reset state ----------
      tick(); tick();
      check("rst_arvalid", 64'(bus.arvalid), 64'd0);
      check("rst_gnt",     64'(bus.ch_gnt), 64'd0);
      check("rst_araddr",  64'(bus.araddr), 64'd0);
      check("rst_arlen",   64'(bus.arlen), 64'd0);
      check("rst_arid",    64'(bus.arid), 64'd0);
      check("rst_outs",    64'(bus.outs_cnt), 64'd0);
      check("rst_err",     64'(bus.err_underflow), 64'd0);
      check("arsize",      64'(bus.arsize), 64'd2);
      check("arburst",     64'(bus.arburst), 64'd1);
      areset = 1'b0;

      // ---------- single request ----------
      bus.ch_req = 8'h04;
      bus.ch_addr[32*2 +: 32] = 32'h1000_0040;
      bus.ch_len[B*2 +: B]    = 8'h0F;
      bus.arready = 1'b1;
      tick();
      check("single_arvalid", 64'(bus.arvalid), 64'd1);
      check("single_araddr",  64'(bus.araddr), 64'h1000_0040);
      check("single_arlen",   64'(bus.arlen), 64'h0F);
      check("single_arid",    64'(bus.arid), 64'd2);
      check("single_gnt_pre", 64'(bus.ch_gnt), 64'd0);
      tick();
      check("single_gnt",     64'(bus.ch_gnt), 64'h04);
      check("single_outs",    64'(bus.outs_cnt), 64'd1);
      check("single_arvalid0",64'(bus.arvalid), 64'd0);
      bus.ch_req = 8'h00;
      tick();
      check("single_gnt_once",64'(bus.ch_gnt), 64'd0);
      rlast_beat();
      check("single_retire",  64'(bus.outs_cnt), 64'd0);
      check("single_no_err",  64'(bus.err_underflow), 64'd0);

      // ---------- underflow, then reset during ADDR ----------
      rlast_beat();
      check("uflow_err",  64'(bus.err_underflow), 64'd1);
      check("uflow_outs", 64'(bus.outs_cnt), 64'd0);
      bus.ch_req  = 8'h10;
      bus.arready = 1'b0;
      tick();
      check("rstaddr_arvalid", 64'(bus.arvalid), 64'd1);
      check("rstaddr_arid",    64'(bus.arid), 64'd4);
      bus.arready = 1'b1;
      areset = 1'b1;
      tick();
      check("rstaddr_drop",  64'(bus.arvalid), 64'd0);
      check("rstaddr_err",   64'(bus.err_underflow), 64'd0);
      check("rstaddr_gnt",   64'(bus.ch_gnt), 64'd0);
      check("rstaddr_araddr",64'(bus.araddr), 64'd0);
      areset = 1'b0;
      bus.ch_req = 8'h00;
      tick();
      check("rstaddr_nognt", 64'(bus.ch_gnt), 64'd0);
      check("rstaddr_outs",  64'(bus.outs_cnt), 64'd0);

      // ---------- backpressure ----------
      bus.ch_addr[32*5 +: 32] = 32'h2000_0500;
      bus.ch_len[B*5 +: B]    = 8'h03;
      bus.ch_req  = 8'h20;
      bus.arready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_arvalid%0d", i), 64'(bus.arvalid), 64'd1);
         check($sformatf("bp_araddr%0d", i),  64'(bus.araddr), 64'h2000_0500);
         check($sformatf("bp_arlen%0d", i),   64'(bus.arlen), 64'h03);
         check($sformatf("bp_arid%0d", i),    64'(bus.arid), 64'd5);
         check($sformatf("bp_gnt%0d", i),     64'(bus.ch_gnt), 64'd0);
         bus.ch_req = bp_req[i];
         if (i < 4) tick();
      end
      bus.arready = 1'b1;
      bus.ch_req  = 8'h00;
      tick();
      check("bp_gnt",      64'(bus.ch_gnt), 64'h20);
      check("bp_outs",     64'(bus.outs_cnt), 64'd1);
      check("bp_arvalid0", 64'(bus.arvalid), 64'd0);
      tick();
      check("bp_gnt_once", 64'(bus.ch_gnt), 64'd0);
      check("bp_idle",     64'(bus.arvalid), 64'd0);
      rlast_beat();
      check("bp_retire",   64'(bus.outs_cnt), 64'd0);

      // ---------- round-robin over all channels ----------
      do_reset();
      bus.ch_req  = 8'hFF;
      bus.arready = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) begin
         check($sformatf("rr_arvalid%0d", i), 64'(bus.arvalid), 64'd1);
         check($sformatf("rr_arid%0d", i),    64'(bus.arid), 64'(exp_id(i % 8)));
         tick();
         check($sformatf("rr_gnt%0d", i),     64'(bus.ch_gnt), 64'(8'(1) << exp_id(i % 8)));
         check($sformatf("rr_outs%0d", i),    64'(bus.outs_cnt), 64'd1);
         bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
         tick();
         bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
         check($sformatf("rr_retire%0d", i),  64'(bus.outs_cnt), 64'd0);
      end

      // ---------- simultaneous events and full ----------
      do_reset();
      bus.ch_req  = 8'hFF;
      bus.arready = 1'b1;
      tick(); tick(); tick(); tick();
      check("sim_outs2",    64'(bus.outs_cnt), 64'd2);
      tick();
      check("sim_arvalid",  64'(bus.arvalid), 64'd1);
      check("sim_arid",     64'(bus.arid), 64'(exp_id(2)));
      bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
      tick();
      bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
      check("sim_outs_hold",64'(bus.outs_cnt), 64'd2);
      check("sim_gnt",      64'(bus.ch_gnt), 64'(8'(1) << exp_id(2)));
      tick(); tick();
      check("full_outs3",   64'(bus.outs_cnt), 64'd3);
      tick(); tick();
      check("full_outs4",   64'(bus.outs_cnt), 64'd4);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("full_noarvalid%0d", i), 64'(bus.arvalid), 64'd0);
         check($sformatf("full_outs%0d", i),      64'(bus.outs_cnt), 64'd4);
      end
      rlast_beat();
      check("full_dec_outs",    64'(bus.outs_cnt), 64'd3);
      check("full_dec_arvalid", 64'(bus.arvalid), 64'd0);
      bus.arready = 1'b0;
      tick();
      check("full_resume",      64'(bus.arvalid), 64'd1);
      check("full_resume_arid", 64'(bus.arid), 64'(exp_id(5)));
      tick();
      check("full_cap",         64'(bus.outs_cnt), 64'd3);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
